// File: rtl/cache_way_store.sv
// cache_way_store: per-way valid/dirty/tag/line arrays with tree PLRU per set,
// registered read outputs, tag compare, way selection and PLRU update.
module cache_way_store #(
   parameter int s_offset = 5,
   parameter int s_index  = 3,
   parameter int s_tag    = 32 - s_offset - s_index,
   parameter int s_mask   = 2**s_offset,
   parameter int s_line   = 8*s_mask,
   parameter int s_way    = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          read,
   input  logic [s_index-1:0]            rindex,
   input  logic [s_index-1:0]            windex,
   input  logic [2**s_way-1:0]           load_way,
   input  logic [s_mask-1:0]             wmask,
   input  logic [s_tag-1:0]              tag_in,
   input  logic                          dirty_in,
   input  logic [s_line-1:0]             line_in,
   input  logic                          lru_update,
   output logic [2**s_way-1:0]           valids,
   output logic [2**s_way-1:0]           dirtys,
   output logic [(2**s_way)*s_tag-1:0]   tags,
   output logic [(2**s_way)*s_line-1:0]  datas,
   output logic [2**s_way-1:0]           hits,
   output logic                          hit,
   output logic [2**s_way-1:0]           way,
   output logic [2**s_way-2:0]           lru
);
   localparam int num_sets = 2**s_index;
   localparam int num_ways = 2**s_way;

   logic [num_ways-1:0] valid_mem [num_sets];
   logic [num_ways-1:0] dirty_mem [num_sets];
   logic [num_ways-2:0] lru_mem   [num_sets];
   logic [s_tag-1:0]    tag_mem   [num_ways][num_sets];
   logic [s_line-1:0]   line_mem  [num_ways][num_sets];
   logic [s_line-1:0]   merged    [num_ways];
   logic [num_ways-1:0] fwd_way;
   logic [s_way-1:0]    node, victim_idx, way_idx;
   logic [num_ways-2:0] new_lru;
   logic                bit_sel;

   assign fwd_way = {num_ways{rindex == windex}} & load_way;
   assign hit     = |hits;

   // line as it will read back after this edge's byte-masked write
   always_comb begin
      for (int i = 0; i < num_ways; i++) begin
         merged[i] = line_mem[i][windex];
         for (int b = 0; b < s_mask; b++)
            if (wmask[b]) merged[i][8*b +: 8] = line_in[8*b +: 8];
      end
   end

   always_comb begin
      hits = '0;
      for (int i = 0; i < num_ways; i++)
         hits[i] = valids[i] && (tags[i*s_tag +: s_tag] == tag_in);
   end

   // tree walk: each node bit names the half holding the victim
   always_comb begin
      node       = '0;
      victim_idx = '0;
      for (int l = 0; l < s_way; l++) begin
         bit_sel                 = lru[node];
         victim_idx[s_way-1-l]   = bit_sel;
         node                    = s_way'(2*int'(node) + 1 + int'(bit_sel));
      end
      way_idx = victim_idx;
      for (int i = num_ways-1; i >= 0; i--)
         if (hits[i]) way_idx = s_way'(i);
      way          = '0;
      way[way_idx] = 1'b1;
      new_lru      = lru;
      node         = '0;
      for (int l = 0; l < s_way; l++) begin
         bit_sel       = way_idx[s_way-1-l];
         new_lru[node] = ~bit_sel;
         node          = s_way'(2*int'(node) + 1 + int'(bit_sel));
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n)
         for (int i = 0; i < num_ways; i++)
            if (load_way[i]) begin
               tag_mem[i][windex]  <= tag_in;
               line_mem[i][windex] <= merged[i];
            end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int s = 0; s < num_sets; s++) begin
            valid_mem[s] <= '0;
            dirty_mem[s] <= '0;
            lru_mem[s]   <= '0;
         end
      end else begin
         for (int i = 0; i < num_ways; i++)
            if (load_way[i]) begin
               valid_mem[windex][i] <= 1'b1;
               dirty_mem[windex][i] <= dirty_in;
            end
         if (lru_update) lru_mem[windex] <= new_lru;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valids <= '0;
         dirtys <= '0;
         tags   <= '0;
         datas  <= '0;
         lru    <= '0;
      end else if (read) begin
         for (int i = 0; i < num_ways; i++) begin
            valids[i]                  <= valid_mem[rindex][i] | fwd_way[i];
            dirtys[i]                  <= fwd_way[i] ? dirty_in : dirty_mem[rindex][i];
            tags[i*s_tag +: s_tag]     <= fwd_way[i] ? tag_in : tag_mem[i][rindex];
            datas[i*s_line +: s_line]  <= fwd_way[i] ? merged[i] : line_mem[i][rindex];
         end
         lru <= (rindex == windex && lru_update) ? new_lru : lru_mem[rindex];
      end
   end
endmodule

// File: tb/tb_cache_way_store.sv
// tb_cache_way_store: randomized + directed stimulus against an array-level
// reference model; expected outputs are queued and checked by a monitor.
module tb_cache_way_store;
   logic          clk = 0;
   logic          rst_n = 0;
   logic          read = 0;
   logic [2:0]    rindex = 0, windex = 0;
   logic [3:0]    load_way = 0;
   logic [31:0]   wmask = 0;
   logic [23:0]   tag_in = 0;
   logic          dirty_in = 0;
   logic [255:0]  line_in = 0;
   logic          lru_update = 0;
   logic [3:0]    valids, dirtys, hits, way;
   logic          hit;
   logic [95:0]   tags;
   logic [1023:0] datas;
   logic [2:0]    lru;

   cache_way_store dut (
      .clk(clk), .rst_n(rst_n), .read(read), .rindex(rindex), .windex(windex),
      .load_way(load_way), .wmask(wmask), .tag_in(tag_in), .dirty_in(dirty_in),
      .line_in(line_in), .lru_update(lru_update), .valids(valids), .dirtys(dirtys),
      .tags(tags), .datas(datas), .hits(hits), .hit(hit), .way(way), .lru(lru)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]    v, d, k;
      logic [95:0]   t;
      logic [1023:0] dat;
      logic [2:0]    l;
      logic [23:0]   tg;
   } exp_t;

   exp_t q[$];
   int errors = 0, checks = 0;

   logic [3:0]   mv [8], md [8];
   logic [2:0]   ml [8];
   logic [23:0]  mt [4][8];
   logic [255:0] mline [4][8];
   logic         mk [4][8];
   logic [3:0]   ov = 0, od = 0, ok = 0;
   logic [95:0]  ot = 0;
   logic [1023:0] odat = 0;
   logic [2:0]   ol = 0;

   function automatic logic [1:0] victim(logic [2:0] l);
      return l[0] ? (l[2] ? 2'd3 : 2'd2) : (l[1] ? 2'd1 : 2'd0);
   endfunction

   function automatic logic [2:0] touch(logic [2:0] l, logic [1:0] w);
      case (w)
         2'd0:    return {l[2], 1'b1, 1'b1};
         2'd1:    return {l[2], 1'b0, 1'b1};
         2'd2:    return {1'b1, l[1], 1'b0};
         default: return {1'b0, l[1], 1'b0};
      endcase
   endfunction

   function automatic logic [3:0] hit_mask(logic [3:0] v, logic [95:0] t, logic [23:0] tg);
      logic [3:0] h = 0;
      for (int i = 0; i < 4; i++) h[i] = v[i] && t[i*24 +: 24] == tg;
      return h;
   endfunction

   function automatic logic [1:0] pick(logic [3:0] h, logic [2:0] l);
      for (int i = 0; i < 4; i++) if (h[i]) return 2'(i);
      return victim(l);
   endfunction

   task automatic chk(input string n, input logic [1023:0] a, input logic [1023:0] x);
      checks++;
      if (a !== x) begin
         errors++;
         $display("FAIL %s got %0h want %0h", n, a, x);
      end
   endtask

   task automatic cyc(input logic rd, input logic [2:0] ri, input logic [2:0] wi,
                      input logic [3:0] lw, input logic [31:0] wm, input logic [23:0] tg,
                      input logic di, input logic [255:0] li, input logic lu, input logic rn);
      logic [1:0] w;
      @(negedge clk);
      read = rd; rindex = ri; windex = wi; load_way = lw; wmask = wm;
      tag_in = tg; dirty_in = di; line_in = li; lru_update = lu; rst_n = rn;
      w = pick(hit_mask(ov, ot, tg), ol);
      if (!rn) begin
         for (int s = 0; s < 8; s++) begin
            mv[s] = 0; md[s] = 0; ml[s] = 0;
            for (int i = 0; i < 4; i++) mk[i][s] = 0;
         end
         ov = 0; od = 0; ot = 0; odat = 0; ol = 0; ok = 4'hF;
      end else begin
         for (int i = 0; i < 4; i++)
            if (lw[i]) begin
               mv[wi][i] = 1; md[wi][i] = di; mt[i][wi] = tg; mk[i][wi] = 1;
               for (int b = 0; b < 32; b++)
                  if (wm[b]) mline[i][wi][8*b +: 8] = li[8*b +: 8];
            end
         if (lu) ml[wi] = touch(ol, w);
         if (rd) begin
            ov = mv[ri]; od = md[ri]; ol = ml[ri];
            for (int i = 0; i < 4; i++) begin
               ot[i*24 +: 24] = mt[i][ri];
               odat[i*256 +: 256] = mline[i][ri];
               ok[i] = mk[i][ri];
            end
         end
      end
      q.push_back('{v: ov, d: od, k: ok, t: ot, dat: odat, l: ol, tg: tg});
   endtask

   always @(posedge clk) begin
      exp_t e;
      logic [3:0] eh, ew;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         eh = hit_mask(e.v, e.t, e.tg);
         ew = 4'b1 << pick(eh, e.l);
         chk("valids", valids, e.v);
         chk("dirtys", dirtys & e.v, e.d & e.v);
         chk("lru", lru, e.l);
         chk("hits", hits, eh);
         chk("hit", hit, |eh);
         chk("way", way, ew);
         for (int i = 0; i < 4; i++)
            if (e.k[i]) begin
               chk($sformatf("tag%0d", i), tags[i*24 +: 24], e.t[i*24 +: 24]);
               chk($sformatf("data%0d", i), datas[i*256 +: 256], e.dat[i*256 +: 256]);
            end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic [255:0] pat, ones, li;
      logic [23:0] ptags [5];
      ptags = '{24'hA00001, 24'hB00002, 24'hC00003, 24'hD00004, 24'hE00005};
      ones = '1;
      for (int j = 0; j < 8; j++) pat[32*j +: 32] = 32'h1234_5670 + j;
      cyc(1, 0, 0, 4'hF, '1, 24'h777777, 1, ones, 1, 0);
      cyc(1, 0, 0, 4'hF, '1, 24'h777777, 1, ones, 1, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 3, 4'b0001, '1, 24'hABCDEF, 1, pat, 0, 1);
      cyc(1, 3, 0, 0, 0, 24'hABCDEF, 0, 0, 0, 1);
      cyc(1, 3, 0, 0, 0, 24'h123456, 0, 0, 0, 1);
      cyc(1, 5, 5, 4'b0010, '1, 24'h111111, 0, ~pat, 0, 1);
      cyc(0, 5, 5, 4'b0010, '1, 24'h222222, 1, pat, 0, 1);
      cyc(1, 5, 0, 0, 0, 24'h222222, 0, 0, 0, 1);
      cyc(0, 0, 6, 4'b0100, '1, 24'h666666, 0, ones, 0, 1);
      cyc(0, 0, 6, 4'b0100, 32'h1, 24'h666666, 0, 0, 0, 1);
      cyc(1, 6, 0, 0, 0, 24'h666666, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) cyc(0, 0, 2, 4'b1 << i, '1, ptags[i], 0, pat ^ 256'(i), 0, 1);
      cyc(1, 2, 0, 0, 0, ptags[0], 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) cyc(1, 2, 2, 0, 0, ptags[i], 0, 0, 1, 1);
      cyc(0, 2, 2, 0, 0, ptags[4], 0, 0, 0, 1);
      cyc(1, 3, 3, 4'hF, '1, 24'hABCDEF, 1, pat, 1, 0);
      cyc(1, 3, 0, 0, 0, 24'hABCDEF, 0, 0, 0, 1);
      for (int n = 0; n < 600; n++) begin
         for (int j = 0; j < 8; j++) li[32*j +: 32] = $urandom;
         cyc(1'($urandom), 3'($urandom), 3'($urandom),
             ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0,
             $urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'($urandom),
             24'h5A0000 + 24'($urandom_range(0, 3)), 1'($urandom), li,
             1'($urandom), $urandom_range(0, 60) != 0);
      end
      for (int n = 0; n < 10 && q.size() > 0; n++) @(negedge clk);
      if (q.size() > 0) begin
         errors++;
         $display("FAIL drain queue left %0d want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
